// File: rtl/cube_frame_assembler_pkg.sv
// Shared types and frame geometry for the cube frame assembler: element/frame
// types, FSM state encoding and the stream-index to frame-coordinate mapping.
package cube_frame_pkg;

    localparam int unsigned ELEM_W = 3;

    localparam int unsigned D0_L = 3;
    localparam int unsigned D0_R = 4;
    localparam int unsigned D1_L = 3;
    localparam int unsigned D1_R = 2;
    localparam int unsigned D2_L = 2;
    localparam int unsigned D2_R = 4;
    localparam int unsigned D3_L = 2;
    localparam int unsigned D3_R = 2;

    localparam int unsigned D0_N = 2;
    localparam int unsigned D1_N = 2;
    localparam int unsigned D2_N = 3;
    localparam int unsigned D3_N = 1;

    localparam int unsigned N_ELEM = D0_N * D1_N * D2_N * D3_N;

    typedef logic [0:ELEM_W-1] elem_t;
    typedef elem_t frame_t [D0_L:D0_R][D1_L:D1_R][D2_L:D2_R][D3_L:D3_R];

    typedef enum logic [1:0] {FILL, HOLD, DROP} asm_state_e;

    typedef struct packed {
        logic [2:0] i0;
        logic [1:0] i1;
        logic [2:0] i2;
        logic [1:0] i3;
    } coord_t;

    // Mixed-radix decode, last dimension fastest; dim 1 counts downward.
    function automatic coord_t k_to_coord(input logic [3:0] k);
        coord_t      c;
        int unsigned r;
        r    = 32'(k);
        c.i3 = 2'(D3_L + r % D3_N);
        r    = r / D3_N;
        c.i2 = 3'(D2_L + r % D2_N);
        r    = r / D2_N;
        c.i1 = 2'(D1_L - r % D1_N);
        r    = r / D1_N;
        c.i0 = 3'(D0_L + r % D0_N);
        return c;
    endfunction

endpackage

// File: rtl/cube_frame_assembler_if.sv
// Element-stream input and frame-output handshakes of the cube frame assembler.
interface cube_frame_if;
    import cube_frame_pkg::*;

    logic   in_valid;
    logic   in_ready;
    elem_t  in_data;
    logic   in_last;
    logic   out_valid;
    logic   out_ready;
    frame_t out_frame;
    logic   err_short;
    logic   err_long;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_frame, err_short, err_long
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_frame, err_short, err_long
    );

endinterface

// File: rtl/cube_frame_assembler_slot.sv
// Single-entry output register slot: loads a whole frame, holds it until taken.
module cube_frame_slot
    import cube_frame_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  frame_t frame_d,
    input  logic   ready,
    output logic   valid,
    output frame_t frame_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            frame_q <= '{default: '0};
        end else if (load) begin
            valid   <= 1'b1;
            frame_q <= frame_d;
        end else if (ready) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/cube_frame_assembler.sv
// Assembles a serial 3-bit element stream into 12-element frames, padding short
// frames and discarding the tail of long ones; the output slot is a sub-module.
module cube_frame_assembler
    import cube_frame_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cube_frame_if.slave  bus
);

    localparam logic [3:0] LAST_K = 4'(N_ELEM - 1);

    asm_state_e state, state_d;
    logic [3:0] cnt, cnt_d;
    frame_t     fbuf, fbuf_d, frame_w, load_frame;
    coord_t     wc;
    logic       load, long_pend, long_d;
    logic       es_d, el_d, err_short_q, err_long_q;
    logic       accept, slot_free;

    assign bus.in_ready  = (state != HOLD);
    assign accept        = bus.in_valid && bus.in_ready;
    assign slot_free     = !bus.out_valid || bus.out_ready;
    assign bus.err_short = err_short_q;
    assign bus.err_long  = err_long_q;

    // Padding needs no logic: the buffer is cleared on every transfer, so
    // slots past a short frame's last element are already zero.
    always_comb begin
        wc      = k_to_coord(cnt);
        frame_w = fbuf;
        if (state == FILL && accept) begin
            frame_w[wc.i0][wc.i1][wc.i2][wc.i3] = bus.in_data;
        end

        state_d    = state;
        cnt_d      = cnt;
        fbuf_d     = fbuf;
        load       = 1'b0;
        load_frame = frame_w;
        long_d     = long_pend;
        es_d       = 1'b0;
        el_d       = 1'b0;

        case (state)
            FILL: begin
                if (accept) begin
                    fbuf_d = frame_w;
                    cnt_d  = cnt + 4'd1;
                    if (bus.in_last || cnt == LAST_K) begin
                        cnt_d = '0;
                        es_d  = bus.in_last && (cnt != LAST_K);
                        el_d  = !bus.in_last && (cnt == LAST_K);
                        if (slot_free) begin
                            load    = 1'b1;
                            fbuf_d  = '{default: '0};
                            state_d = el_d ? DROP : FILL;
                        end else begin
                            state_d = HOLD;
                            long_d  = el_d;
                        end
                    end
                end
            end
            HOLD: begin
                load_frame = fbuf;
                if (slot_free) begin
                    load    = 1'b1;
                    fbuf_d  = '{default: '0};
                    long_d  = 1'b0;
                    state_d = long_pend ? DROP : FILL;
                end
            end
            DROP: begin
                if (accept && bus.in_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            cnt         <= '0;
            fbuf        <= '{default: '0};
            long_pend   <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            fbuf        <= fbuf_d;
            long_pend   <= long_d;
            err_short_q <= es_d;
            err_long_q  <= el_d;
        end
    end

    cube_frame_slot u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .frame_d (load_frame),
        .ready   (bus.out_ready),
        .valid   (bus.out_valid),
        .frame_q (bus.out_frame)
    );

endmodule

// File: tb/tb_cube_frame_assembler.sv
// Scoreboard bench for cube_frame_assembler: stimulus pushes expected frames,
// a negedge monitor pops and compares every frame the DUT hands over.
module tb_cube_frame_assembler;
    import cube_frame_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cube_frame_if bus();

    cube_frame_assembler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_exp;
    logic [2:0]  t0[12];
    logic [1:0]  t1[12];
    logic [2:0]  t2[12];
    logic [35:0] mframe;
    int          mcnt;
    bit          mdrop;
    int          ready_mode;

    function automatic logic [35:0] pack_out();
        logic [35:0] p;
        p = '0;
        for (int k = 0; k < 12; k++) begin
            p[3*k +: 3] = bus.out_frame[t0[k]][t1[k]][t2[k]][2];
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // out_ready only moves just after a rising edge, so the negedge monitor
    // always sees the value the next edge will use.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_unexpected: got %0h expected none at %0t", pack_out(), $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("frame", pack_out(), mon_exp);
            end
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beat(input logic [2:0] d, input bit last, input int gap);
        bit rdy;
        bit acc;
        bit es;
        bit el;
        int n;
        if (gap > 0) idle(gap);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        acc = 1'b0;
        es  = 1'b0;
        el  = 1'b0;
        n   = 0;
        while (!acc && n < 1000) begin
            rdy = bus.in_ready;
            if (rdy) begin
                acc = 1'b1;
                if (mdrop) begin
                    if (last) mdrop = 1'b0;
                end else begin
                    mframe[3*mcnt +: 3] = d;
                    mcnt++;
                    if (mcnt == 12 || last) begin
                        es = last && (mcnt < 12);
                        el = !last && (mcnt == 12);
                        exp_q.push_back(mframe);
                        mframe = '0;
                        mcnt   = 0;
                        if (el) mdrop = 1'b1;
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        end else begin
            check("err_short", 36'(bus.err_short), 36'(es));
            check("err_long", 36'(bus.err_long), 36'(el));
        end
    endtask

    task automatic send_frame(input int len, input int base, input bit rnd);
        int gap;
        for (int i = 0; i < len; i++) begin
            gap = 0;
            if (rnd && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 2);
            send_beat(3'((base + i) % 8), (i == len - 1), gap);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 36'(bus.out_valid), 36'(0));
        check({tag, "_err_short"}, 36'(bus.err_short), 36'(0));
        check({tag, "_err_long"}, 36'(bus.err_long), 36'(0));
        check({tag, "_in_ready"}, 36'(bus.in_ready), 36'(1));
        check({tag, "_out_frame"}, pack_out(), 36'(0));
    endtask

    initial begin
        int k;
        int n;
        int len;
        int r;
        k = 0;
        for (int a = 3; a <= 4; a++)
            for (int b = 3; b >= 2; b--)
                for (int c = 2; c <= 4; c++) begin
                    t0[k] = 3'(a);
                    t1[k] = 2'(b);
                    t2[k] = 3'(c);
                    k++;
                end

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        ready_mode    = 1;
        mframe        = '0;
        mcnt          = 0;
        mdrop         = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        idle(2);

        // Full frame, data k mod 8, consumer always ready.
        send_frame(12, 0, 1'b0);
        check("t1_out_valid", 36'(bus.out_valid), 36'(1));
        check("t1_elem_first", 36'(bus.out_frame[3][3][2][2]), 36'(0));
        check("t1_elem_last", 36'(bus.out_frame[4][2][4][2]), 36'(3));
        idle(3);

        // Two frames against a stalled consumer: second one parks in HOLD.
        ready_mode = 0;
        idle(2);
        send_frame(12, 8, 1'b0);
        send_frame(12, 20, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd7;
        bus.in_last  = 1'b0;
        repeat (3) begin
            check("t2_hold_in_ready", 36'(bus.in_ready), 36'(0));
            check("t2_hold_out_valid", 36'(bus.out_valid), 36'(1));
            @(negedge clk);
        end
        idle(0);
        ready_mode = 1;
        @(negedge clk);
        check("t2_swap_valid_a", 36'(bus.out_valid), 36'(1));
        @(negedge clk);
        check("t2_swap_valid_b", 36'(bus.out_valid), 36'(1));
        check("t2_in_ready_back", 36'(bus.in_ready), 36'(1));
        idle(3);

        // Short frame: last on beat 4.
        send_frame(5, 0, 1'b0);
        idle(1);
        check("t3_short_single", 36'(bus.err_short), 36'(0));
        idle(2);

        // Long frame: 15 beats, then a clean frame.
        send_frame(15, 0, 1'b0);
        idle(1);
        check("t4_long_idle", 36'(bus.err_long), 36'(0));
        send_frame(12, 5, 1'b0);
        idle(3);

        // Reset mid-frame with a frame pending in the slot.
        ready_mode = 0;
        idle(2);
        send_frame(12, 1, 1'b0);
        for (int i = 0; i < 6; i++) send_beat(3'(i + 2), 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t5_reset");
        exp_q.delete();
        mframe = '0;
        mcnt   = 0;
        mdrop  = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        idle(2);
        send_frame(12, 6, 1'b0);
        idle(3);

        // Random valid gaps, random consumer stalls, mixed frame lengths.
        ready_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      len = 12;
            else if (r < 9) len = $urandom_range(1, 11);
            else            len = $urandom_range(13, 15);
            send_frame(len, $urandom_range(0, 7), 1'b1);
        end
        idle(1);
        ready_mode = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 36'(exp_q.size()), 36'(0));
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
